// File: rtl/fmul_pkg.sv
// Shared types for the arbitrated single-precision multiplier.
package fmul_pkg;

  localparam int FP_W      = 32;
  localparam int TAG_MAX_W = 4;  // covers the largest requester count (16)

  typedef logic [FP_W-1:0] fp_t;

  typedef struct packed {
    logic                 vld;
    logic [TAG_MAX_W-1:0] tag;
    fp_t                  z;
  } fmul_stage_t;

endpackage

// File: rtl/fmul.sv
// Combinational single-precision multiply: XOR sign, truncated mantissa,
// zero-operand check, no NaN/Inf/denormal handling.
module fmul
  import fmul_pkg::*;
(
  input  fp_t a,
  input  fp_t b,
  output fp_t z
);

  logic        sign;
  logic        zero_op;
  logic [23:0] ma;
  logic [23:0] mb;
  logic [47:0] prod;
  logic [9:0]  exp_base;
  logic [9:0]  exp_norm;
  logic        unused_bits;

  assign sign     = a[31] ^ b[31];
  assign zero_op  = (a[30:0] == 31'd0) || (b[30:0] == 31'd0);
  assign ma       = {1'b1, a[22:0]};
  assign mb       = {1'b1, b[22:0]};
  assign prod     = ma * mb;
  assign exp_base = {2'b00, a[30:23]} + {2'b00, b[30:23]} - 10'd127;
  assign exp_norm = exp_base + 10'd1;
  assign unused_bits = ^{prod[22:0], exp_base[9:8], exp_norm[9:8]};

  // Product of two 1.x mantissas lies in [1,4); renormalise on the top bit.
  always_comb begin
    z = '0;
    if (zero_op) begin
      z = {sign, 31'd0};
    end else if (prod[47]) begin
      z = {sign, exp_norm[7:0], prod[46:24]};
    end else begin
      z = {sign, exp_base[7:0], prod[45:23]};
    end
  end

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first request at or above ptr, wrapping.
module rr_arbiter #(
  parameter  int N  = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  input  logic          en,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx
);

  logic [IW-1:0] idx;
  logic          found;
  logic          hit;

  // Walk the requesters starting at ptr; the first hit wins.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = '0;
    hit     = 1'b0;
    for (int k = 0; k < N; k++) begin
      idx      = IW'((int'(ptr) + k) % N);
      hit      = en && !found && req[idx];
      gnt[idx] = gnt[idx] | hit;
      gnt_idx  = hit ? idx : gnt_idx;
      found    = found | hit;
    end
  end

endmodule

// File: rtl/fmul_arbiter.sv
// Round-robin sharing of one fmul between NREQ requesters, with a PIPE-deep
// result pipeline that freezes as a whole under response backpressure.
module fmul_arbiter
  import fmul_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int PIPE = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req_valid,
  output logic [NREQ-1:0]           req_ready,
  input  logic [NREQ-1:0][FP_W-1:0] req_a,
  input  logic [NREQ-1:0][FP_W-1:0] req_b,
  output logic [NREQ-1:0]           resp_valid,
  input  logic [NREQ-1:0]           resp_ready,
  output logic [FP_W-1:0]           resp_z
);

  localparam int TAG_W = $clog2(NREQ);

  fmul_stage_t      stage_r [PIPE];
  logic [TAG_W-1:0] rr_r;
  logic [TAG_W-1:0] gnt_idx;
  logic [NREQ-1:0]  gnt;
  logic             last_vld;
  logic             last_ready;
  logic             adv;
  logic             granted;
  fp_t              mul_a;
  fp_t              mul_b;
  fp_t              mul_z;

  assign last_vld = stage_r[PIPE-1].vld;
  assign adv      = !last_vld || last_ready;
  assign granted  = |gnt;
  assign mul_a    = req_a[gnt_idx];
  assign mul_b    = req_b[gnt_idx];

  // Gating with !rst keeps handshakes quiet during the reset cycle itself.
  rr_arbiter #(.N(NREQ)) u_arb (
    .req     (req_valid),
    .ptr     (rr_r),
    .en      (adv && !rst),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  fmul u_fmul (
    .a (mul_a),
    .b (mul_b),
    .z (mul_z)
  );

  assign req_ready = gnt;
  assign resp_z    = rst ? '0 : stage_r[PIPE-1].z;

  // Decode the last-stage tag into per-requester valid and ready select.
  always_comb begin
    last_ready = 1'b0;
    resp_valid = '0;
    for (int i = 0; i < NREQ; i++) begin
      last_ready    = last_ready | (resp_ready[i] && (stage_r[PIPE-1].tag == TAG_MAX_W'(i)));
      resp_valid[i] = last_vld && !rst && (stage_r[PIPE-1].tag == TAG_MAX_W'(i));
    end
  end

  // Lock-step pipeline advance and round-robin pointer update.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < PIPE; k++) begin
        stage_r[k] <= '0;
      end
      rr_r <= '0;
    end else if (adv) begin
      stage_r[0].vld <= granted;
      stage_r[0].tag <= TAG_MAX_W'(gnt_idx);
      stage_r[0].z   <= mul_z;
      for (int k = 1; k < PIPE; k++) begin
        stage_r[k] <= stage_r[k-1];
      end
      if (granted) begin
        rr_r <= (gnt_idx == TAG_W'(NREQ - 1)) ? '0 : gnt_idx + TAG_W'(1);
      end else begin
        rr_r <= rr_r;
      end
    end else begin
      rr_r <= rr_r;
    end
  end

endmodule
